pe_array_sequencer: RTL and testbench
=====================================

// Module: pe_array_sequencer
// PURPOSE
//  Upstream control stage of the tile_pe array: turns a streamed weight tensor and x vector into
//  the global_state / cfg_addr / cfg_data / cfg_valid / x_in drive shared by all PEs.
//  Runs one job per start pulse: CLR -> LOAD_W -> LOAD_X -> MAC -> IDLE, then pulses done.
//  All outputs registered; one instance per tile.
// PARAMETERS
//  DW          8   weight / activation width (signed)
//  ROW_W       4   PE row index width; NROWS = 1<<ROW_W
//  COL_W       4   PE col index width; NCOLS = 1<<COL_W
//  MAC_CYCLES  16  cycles global_state is held at MAC (covers acc propagation; >=1)
// PORTS
//  clk           in   1            rising-edge clock
//  rst           in   1            synchronous active-high reset
//  start         in   1            job request; sampled in IDLE only
//  w_data        in   DW           weight stream, row-major (row 0 col 0 first)
//  w_valid       in   1            w_data valid
//  w_ready       out  1            sequencer accepts weight (LOAD_W only)
//  x_data        in   DW           activation stream
//  x_valid       in   1            x_data valid
//  x_ready       out  1            sequencer accepts activation (LOAD_X only)
//  global_state  out  2            0 LOAD_W, 1 LOAD_X, 2 MAC, 3 clear (PE default branch)
//  cfg_addr      out  ROW_W+COL_W  {row,col} of weight being written
//  cfg_data      out  DW           weight value
//  cfg_valid     out  1            cfg_addr/cfg_data valid this cycle
//  x_out         out  DW           drives PE x_in
//  busy          out  1            high in every state except IDLE
//  done          out  1            one-cycle pulse on MAC->IDLE
// BEHAVIOUR
//  Reset: state=IDLE; global_state=0, cfg_addr=0, cfg_data=0, cfg_valid=0, x_out=0,
//   w_ready=0, x_ready=0, busy=0, done=0; counters cleared. Reset mid-job aborts at once, no done.
//  IDLE: global_state=0, cfg_valid=0 (PEs hold). start=1 -> CLR next cycle. start outside IDLE ignored.
//  CLR: exactly 1 cycle, global_state=3 (zeroes PE accumulators) -> LOAD_W.
//  LOAD_W: global_state=0, w_ready=1. Beat = w_valid&&w_ready. Cycle after a beat: cfg_valid=1,
//   cfg_data=w_data, cfg_addr=beat index k (row=k>>COL_W, col=k[COL_W-1:0]). No beat -> cfg_valid=0,
//   cfg_addr/cfg_data hold. After beat NROWS*NCOLS-1: w_ready drops same edge, cfg write still
//   issued next cycle with global_state=0, then -> LOAD_X (no beat lost, no extra beat accepted).
//  LOAD_X: global_state=1, x_ready=1. Each beat: x_out<=x_data next cycle; no beat -> x_out holds.
//   After NCOLS beats, one further cycle at state 1 so last x_out is captured, then -> MAC.
//  MAC: global_state=2, w_ready=x_ready=0, x_out holds, for exactly MAC_CYCLES cycles -> IDLE, done=1.
//  Counters: weight counter ROW_W+COL_W+1 bits, x counter COL_W+1 bits, MAC counter
//   $clog2(MAC_CYCLES+1) bits; compare to terminal, never wrap mid-state.
//  start asserted in the done cycle is accepted (IDLE is entered that cycle); back-to-back jobs ok.
// CONFIGURATION
//  SEQ_WEIGHT_REUSE_EN defined: adds input reuse_w (1 bit). start&&reuse_w in IDLE with internal
//   w_loaded=1 -> CLR then LOAD_X directly (LOAD_W skipped, weights kept). w_loaded set on LOAD_W
//   exit, cleared by rst. reuse_w with w_loaded=0 behaves as normal start.
//  Not defined: no reuse_w port; every job performs LOAD_W.
// TESTING (ROW_W=1, COL_W=1, MAC_CYCLES=3 unless noted)
//  1 start, weights 1,2,3,4 continuous, x 5,6 -> cfg_valid 4 cycles addr 0,1,2,3 data 1,2,3,4;
//    x_out 5 then 6; global_state seq 3,0..,1..,2,2,2; done 1 cycle; busy low after.
//  2 w_valid gaps (weight 2 delayed 3 cycles) -> cfg_valid low in gap, addr/data hold, total 4 writes.
//  3 w_valid held high past 4th beat -> w_ready low after 4 beats, 5th word not consumed.
//  4 rst during LOAD_X -> next cycle all outputs reset values, no done; new start runs full job.
//  5 start in IDLE + start in done cycle -> second job begins with CLR immediately, start while busy ignored.
//  6 SEQ_WEIGHT_REUSE_EN: job1 normal, job2 reuse_w=1 -> no cfg_valid in job2, state seq 3,1..,2..

Source files
------------

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: per-tile control stage driving global_state / cfg bus / x_in of the PE array.
// Optional feature SEQ_WEIGHT_REUSE_EN adds reuse_w to skip LOAD_W when weights are already resident.
module pe_array_sequencer #(
   parameter int DW         = 8,
   parameter int ROW_W      = 4,
   parameter int COL_W      = 4,
   parameter int MAC_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
`ifdef SEQ_WEIGHT_REUSE_EN
   input  logic                   reuse_w,
`endif
   input  logic [DW-1:0]          w_data,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [DW-1:0]          x_data,
   input  logic                   x_valid,
   output logic                   x_ready,
   output logic [1:0]             global_state,
   output logic [ROW_W+COL_W-1:0] cfg_addr,
   output logic [DW-1:0]          cfg_data,
   output logic                   cfg_valid,
   output logic [DW-1:0]          x_out,
   output logic                   busy,
   output logic                   done
);
   localparam int AW  = ROW_W + COL_W;
   localparam int WCW = AW + 1;
   localparam int XCW = COL_W + 1;
   localparam int MCW = $clog2(MAC_CYCLES + 1);

   localparam logic [WCW-1:0] W_LAST = WCW'((1 << AW) - 1);
   localparam logic [XCW-1:0] X_LAST = XCW'((1 << COL_W) - 1);
   localparam logic [MCW-1:0] M_LAST = MCW'(MAC_CYCLES - 1);

   // W_FLUSH / X_FLUSH are the trailing cycles that emit the last cfg write / last x_out
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLR     = 3'd1;
   localparam logic [2:0] S_LOAD_W  = 3'd2;
   localparam logic [2:0] S_W_FLUSH = 3'd3;
   localparam logic [2:0] S_LOAD_X  = 3'd4;
   localparam logic [2:0] S_X_FLUSH = 3'd5;
   localparam logic [2:0] S_MAC     = 3'd6;

   localparam logic [1:0] GS_LOAD_W = 2'd0;
   localparam logic [1:0] GS_LOAD_X = 2'd1;
   localparam logic [1:0] GS_MAC    = 2'd2;
   localparam logic [1:0] GS_CLR    = 2'd3;

   logic [2:0]     state;
   logic [2:0]     next_state;
   logic [WCW-1:0] w_cnt;
   logic [XCW-1:0] x_cnt;
   logic [MCW-1:0] mac_cnt;
   logic           w_beat;
   logic           x_beat;
   logic           reuse_job;

   logic [1:0]     gs_nxt;
   logic           w_ready_nxt;
   logic           x_ready_nxt;
   logic           busy_nxt;
   logic           done_nxt;
   logic           cfg_valid_nxt;
   logic [AW-1:0]  cfg_addr_nxt;
   logic [DW-1:0]  cfg_data_nxt;
   logic [DW-1:0]  x_out_nxt;

   assign w_beat = w_valid && w_ready;
   assign x_beat = x_valid && x_ready;

`ifdef SEQ_WEIGHT_REUSE_EN
   logic w_loaded;

   // reuse is decided once at job start and only when a full weight set is resident
   always_ff @(posedge clk) begin
      if (rst) begin
         w_loaded  <= 1'b0;
         reuse_job <= 1'b0;
      end else begin
         if (state == S_W_FLUSH) begin
            w_loaded <= 1'b1;
         end
         if ((state == S_IDLE) && start) begin
            reuse_job <= reuse_w && w_loaded;
         end
      end
   end
`else
   assign reuse_job = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) next_state = S_CLR;
            else       next_state = S_IDLE;
         end
         S_CLR: begin
            if (reuse_job) next_state = S_LOAD_X;
            else           next_state = S_LOAD_W;
         end
         S_LOAD_W: begin
            if (w_beat && (w_cnt == W_LAST)) next_state = S_W_FLUSH;
            else                             next_state = S_LOAD_W;
         end
         S_W_FLUSH: next_state = S_LOAD_X;
         S_LOAD_X: begin
            if (x_beat && (x_cnt == X_LAST)) next_state = S_X_FLUSH;
            else                             next_state = S_LOAD_X;
         end
         S_X_FLUSH: next_state = S_MAC;
         S_MAC: begin
            if (mac_cnt == M_LAST) next_state = S_IDLE;
            else                   next_state = S_MAC;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // output logic: values the output registers take at the next edge
   always_comb begin
      case (next_state)
         S_CLR:               gs_nxt = GS_CLR;
         S_LOAD_X, S_X_FLUSH: gs_nxt = GS_LOAD_X;
         S_MAC:               gs_nxt = GS_MAC;
         default:             gs_nxt = GS_LOAD_W;
      endcase
      w_ready_nxt   = (next_state == S_LOAD_W);
      x_ready_nxt   = (next_state == S_LOAD_X);
      busy_nxt      = (next_state != S_IDLE);
      done_nxt      = (state == S_MAC) && (next_state == S_IDLE);
      cfg_valid_nxt = w_beat;
      if (w_beat) begin
         cfg_addr_nxt = w_cnt[AW-1:0];
         cfg_data_nxt = w_data;
      end else begin
         cfg_addr_nxt = cfg_addr;
         cfg_data_nxt = cfg_data;
      end
      if (x_beat) begin
         x_out_nxt = x_data;
      end else begin
         x_out_nxt = x_out;
      end
   end

   // job counters: cleared on entry, stop at terminal count
   always_ff @(posedge clk) begin
      if (rst) begin
         w_cnt   <= WCW'(0);
         x_cnt   <= XCW'(0);
         mac_cnt <= MCW'(0);
      end else begin
         if (state == S_CLR) begin
            w_cnt <= WCW'(0);
            x_cnt <= XCW'(0);
         end else begin
            if (w_beat) w_cnt <= w_cnt + WCW'(1);
            else        w_cnt <= w_cnt;
            if (x_beat) x_cnt <= x_cnt + XCW'(1);
            else        x_cnt <= x_cnt;
         end
         if (state == S_MAC) mac_cnt <= mac_cnt + MCW'(1);
         else                mac_cnt <= MCW'(0);
      end
   end

   // output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         global_state <= 2'd0;
         w_ready      <= 1'b0;
         x_ready      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_valid    <= 1'b0;
         cfg_addr     <= AW'(0);
         cfg_data     <= DW'(0);
         x_out        <= DW'(0);
      end else begin
         global_state <= gs_nxt;
         w_ready      <= w_ready_nxt;
         x_ready      <= x_ready_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         cfg_valid    <= cfg_valid_nxt;
         cfg_addr     <= cfg_addr_nxt;
         cfg_data     <= cfg_data_nxt;
         x_out        <= x_out_nxt;
      end
   end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Bench for pe_array_sequencer (ROW_W=1, COL_W=1, MAC_CYCLES=3); jobs are traced then checked
// against interval rules derived from the handshake beats. Build with SEQ_WEIGHT_REUSE_EN for reuse.
module tb_pe_array_sequencer;
   localparam int DW = 8;
   localparam int ROW_W = 1;
   localparam int COL_W = 1;
   localparam int MAC_CYCLES = 3;
   localparam int AW = ROW_W + COL_W;
   localparam int NW = 1 << AW;
   localparam int NC = 1 << COL_W;
   localparam int MAXC = 256;
   localparam int BUDGET = 200;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] w_data;
   logic          w_valid;
   logic          w_ready;
   logic [DW-1:0] x_data;
   logic          x_valid;
   logic          x_ready;
   logic [1:0]    global_state;
   logic [AW-1:0] cfg_addr;
   logic [DW-1:0] cfg_data;
   logic          cfg_valid;
   logic [DW-1:0] x_out;
   logic          busy;
   logic          done;
`ifdef SEQ_WEIGHT_REUSE_EN
   logic          reuse_w;
`endif

   pe_array_sequencer #(.DW(DW), .ROW_W(ROW_W), .COL_W(COL_W), .MAC_CYCLES(MAC_CYCLES)) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_WEIGHT_REUSE_EN
      .reuse_w(reuse_w),
`endif
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
      .global_state(global_state), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_valid(cfg_valid), .x_out(x_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   int fails = 0;

   int            n;
   bit            wb_t [MAXC];
   bit            xb_t [MAXC];
   logic [1:0]    gs_t [MAXC];
   logic          cv_t [MAXC];
   logic [AW-1:0] ca_t [MAXC];
   logic [DW-1:0] cd_t [MAXC];
   logic [DW-1:0] xo_t [MAXC];
   logic          bz_t [MAXC];
   logic          dn_t [MAXC];
   logic          wr_t [MAXC];
   logic          xr_t [MAXC];

   logic [DW-1:0] wv [NW];
   logic [DW-1:0] xv [NC];
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;
   logic [DW-1:0] exp_x;
   bit            w_loaded_m;

   task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, e, obs, exp);
      end
   endtask

   // one clock: note handshakes offered this cycle, then sample outputs 1 time unit after the edge
   task automatic cyc();
      bit wb, xb;
      wb = (w_valid === 1'b1) && (w_ready === 1'b1);
      xb = (x_valid === 1'b1) && (x_ready === 1'b1);
      @(posedge clk);
      #1;
      if (n < MAXC - 1) n++;
      wb_t[n] = wb;  xb_t[n] = xb;
      gs_t[n] = global_state;  cv_t[n] = cfg_valid;  ca_t[n] = cfg_addr;  cd_t[n] = cfg_data;
      xo_t[n] = x_out;  bz_t[n] = busy;  dn_t[n] = done;  wr_t[n] = w_ready;  xr_t[n] = x_ready;
   endtask

   task automatic chk_rst_outs(input int e);
      chk("rst_gs", e, global_state, 0);
      chk("rst_cfg_addr", e, cfg_addr, 0);
      chk("rst_cfg_data", e, cfg_data, 0);
      chk("rst_cfg_valid", e, cfg_valid, 0);
      chk("rst_x_out", e, x_out, 0);
      chk("rst_w_ready", e, w_ready, 0);
      chk("rst_x_ready", e, x_ready, 0);
      chk("rst_busy", e, busy, 0);
      chk("rst_done", e, done, 0);
      exp_addr = '0;  exp_data = '0;  exp_x = '0;  w_loaded_m = 1'b0;
   endtask

   task automatic idle(input int k);
      start = 1'b0;  w_valid = 1'b0;  x_valid = 1'b0;
      for (int i = 0; i < k; i++) begin
         cyc();
         chk("idle_gs", n, global_state, 0);
         chk("idle_busy", n, busy, 0);
         chk("idle_done", n, done, 0);
         chk("idle_cfg_valid", n, cfg_valid, 0);
         chk("idle_ready", n, {w_ready, x_ready}, 0);
      end
   endtask

   // one job: pct = valid probability, hold_extra keeps valids high after the last word,
   // poke_start toggles start while busy, abort_x>0 resets after that many x beats
   task automatic run_job(input bit directed, input int pct, input bit hold_extra,
                          input bit reuse_req, input bit poke_start, input int abort_x);
      int wi, xi, nwb, nxb, lb, lx, kw, kx, eg;
      bit fin, reuse_exp;
      wi = 0;  xi = 0;  fin = 1'b0;
`ifdef SEQ_WEIGHT_REUSE_EN
      reuse_exp = reuse_req && w_loaded_m;
      reuse_w = reuse_req;
`else
      reuse_exp = 1'b0;
`endif
      for (int i = 0; i < NW; i++) wv[i] = directed ? DW'(i + 1) : DW'($urandom);
      for (int i = 0; i < NC; i++) xv[i] = directed ? DW'(i + 5) : DW'($urandom);
      n = 0;
      start = 1'b1;  w_valid = 1'b0;  x_valid = 1'b0;
      cyc();
      start = 1'b0;
      while (!fin && n < BUDGET) begin
         if (wi < NW) begin
            w_valid = ($urandom_range(99, 0) < pct);  w_data = wv[wi];
         end else begin
            w_valid = hold_extra;  w_data = DW'($urandom);
         end
         if (xi < NC) begin
            x_valid = ($urandom_range(99, 0) < pct);  x_data = xv[xi];
         end else begin
            x_valid = hold_extra;  x_data = DW'($urandom);
         end
         start = poke_start ? 1'($urandom_range(1, 0)) : 1'b0;
         cyc();
         if (wb_t[n]) wi++;
         if (xb_t[n]) xi++;
         if (abort_x > 0 && xi == abort_x) begin
            rst = 1'b1;  start = 1'b0;  w_valid = 1'b0;  x_valid = 1'b0;
            cyc();
            rst = 1'b0;
            chk_rst_outs(n);
            return;
         end
         if (dn_t[n] === 1'b1) fin = 1'b1;
      end
      start = 1'b0;  w_valid = 1'b0;  x_valid = 1'b0;
      chk("job_finished", n, fin, 1);
      if (!fin) return;

      nwb = 0;  nxb = 0;  lb = 1;  lx = 1;
      for (int e = 1; e <= n; e++) begin
         if (wb_t[e]) begin nwb++; lb = e; end
         if (xb_t[e]) begin nxb++; lx = e; end
      end
      chk("w_beats", n, nwb, reuse_exp ? 0 : NW);
      chk("x_beats", n, nxb, NC);
      if (nwb != (reuse_exp ? 0 : NW) || nxb != NC) return;
      chk("done_cycle", n, n, lx + MAC_CYCLES + 1);

      kw = 0;  kx = 0;
      for (int e = 1; e <= n; e++) begin
         if (e == 1)                    eg = 3;
         else if (e <= lb)              eg = 0;
         else if (e <= lx)              eg = 1;
         else if (e <= lx + MAC_CYCLES) eg = 2;
         else                           eg = 0;
         if (wb_t[e]) begin
            exp_addr = AW'(kw);  exp_data = wv[kw];  kw++;
         end
         if (xb_t[e]) begin
            exp_x = xv[kx];  kx++;
         end
         chk("global_state", e, gs_t[e], eg);
         chk("busy", e, bz_t[e], (e <= lx + MAC_CYCLES) ? 1 : 0);
         chk("done", e, dn_t[e], (e == lx + MAC_CYCLES + 1) ? 1 : 0);
         chk("w_ready", e, wr_t[e], (e >= 2 && e <= lb - 1) ? 1 : 0);
         chk("x_ready", e, xr_t[e], (e >= lb + 1 && e <= lx - 1) ? 1 : 0);
         chk("cfg_valid", e, cv_t[e], wb_t[e]);
         chk("cfg_addr", e, ca_t[e], exp_addr);
         chk("cfg_data", e, cd_t[e], exp_data);
         chk("x_out", e, xo_t[e], exp_x);
      end
      w_loaded_m = 1'b1;
   endtask

   initial begin
      n = 0;
      rst = 1'b1;  start = 1'b0;  w_valid = 1'b0;  x_valid = 1'b0;
      w_data = '0;  x_data = '0;
`ifdef SEQ_WEIGHT_REUSE_EN
      reuse_w = 1'b0;
`endif
      cyc();
      cyc();
      chk_rst_outs(n);
      rst = 1'b0;
      idle(2);

      // weights 1..4 and x 5,6 presented without gaps
      run_job(1'b1, 100, 1'b0, 1'b0, 1'b0, 0);
      idle(2);
      // random valid gaps on both streams
      run_job(1'b0, 40, 1'b0, 1'b0, 1'b0, 0);
      idle(1);
      run_job(1'b0, 60, 1'b0, 1'b0, 1'b0, 0);
      idle(1);
      // valids held high past the last word: no extra beat
      run_job(1'b0, 100, 1'b1, 1'b0, 1'b0, 0);
      idle(1);
      // reset while loading x, then a fresh job (reuse request after reset must load weights)
      run_job(1'b0, 70, 1'b0, 1'b0, 1'b0, 1);
      idle(3);
      run_job(1'b0, 70, 1'b0, 1'b1, 1'b0, 0);
      idle(1);
      // start pokes while busy, then back-to-back jobs started in the done cycle
      run_job(1'b0, 80, 1'b0, 1'b0, 1'b1, 0);
      run_job(1'b0, 50, 1'b0, 1'b0, 1'b0, 0);
      run_job(1'b0, 100, 1'b0, 1'b0, 1'b1, 0);
      idle(1);
      // weight reuse request with weights resident, then a normal job
      run_job(1'b0, 70, 1'b0, 1'b1, 1'b0, 0);
      run_job(1'b0, 70, 1'b0, 1'b1, 1'b1, 0);
      idle(1);
      run_job(1'b1, 100, 1'b1, 1'b0, 1'b0, 0);
      idle(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
